// File: rtl/mfp_ahb_dma_master.sv
// mfp_ahb_dma_master: single-channel AHB-lite word copy engine.
// Copies word_cnt 32-bit words from src_addr to dst_addr as a strict sequence
// of SINGLE read and write transfers, with one word in flight at a time.
// Every bus-facing output comes from a register, so nothing on the AHB side
// depends combinationally on start, HREADY or HRDATA.
module mfp_ahb_dma_master #(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_D = 3'd4,
    FIN  = 3'd5
  } state_t;

  // Byte address to word address: the two low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  state_t           state_r, state_s;
  logic [31:0]      src_r, src_s;
  logic [31:0]      dst_r, dst_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      data_r, data_s;
  logic             error_r, error_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [1:0]       htrans_r, htrans_s;
  logic             hwrite_r, hwrite_s;
  logic [31:0]      haddr_r, haddr_s;

  // Next state plus the address, count, data and error updates it implies.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    error_s = error_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          error_s = 1'b0;
          if (word_cnt != CNT_ZERO) begin
            src_s   = word_align(src_addr);
            dst_s   = word_align(dst_addr);
            cnt_s   = word_cnt;
            state_s = RD_A;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_A: begin
        if (HREADY) begin
          state_s = RD_D;
        end else begin
          state_s = RD_A;
        end
      end
      RD_D: begin
        if (HREADY) begin
          if (HRESP) begin
            // A failed read must not be followed by a write of junk data.
            error_s = 1'b1;
            state_s = FIN;
          end else begin
            data_s  = HRDATA;
            state_s = WR_A;
          end
        end else begin
          state_s = RD_D;
        end
      end
      WR_A: begin
        if (HREADY) begin
          state_s = WR_D;
        end else begin
          state_s = WR_A;
        end
      end
      WR_D: begin
        if (HREADY) begin
          if (HRESP) begin
            error_s = 1'b1;
            state_s = FIN;
          end else begin
            // Address arithmetic wraps naturally at 2^32.
            src_s = src_r + 32'd4;
            dst_s = dst_r + 32'd4;
            cnt_s = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_s = FIN;
            end else begin
              state_s = RD_A;
            end
          end
        end else begin
          state_s = WR_D;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus address-phase outputs for the state being entered; HADDR holds in data phases.
  always_comb begin
    htrans_s = HTRANS_IDLE;
    hwrite_s = 1'b0;
    haddr_s  = haddr_r;
    case (state_s)
      RD_A: begin
        htrans_s = HTRANS_NONSEQ;
        haddr_s  = src_s;
      end
      WR_A: begin
        htrans_s = HTRANS_NONSEQ;
        hwrite_s = 1'b1;
        haddr_s  = dst_s;
      end
      default: begin
        htrans_s = HTRANS_IDLE;
      end
    endcase
  end

  assign busy_s = (state_s != IDLE);
  assign done_s = (state_s == FIN);

  // FSM state register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers: current addresses, remaining count, captured word, sticky error.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      src_r   <= 32'd0;
      dst_r   <= 32'd0;
      cnt_r   <= CNT_ZERO;
      data_r  <= 32'd0;
      error_r <= 1'b0;
    end else begin
      src_r   <= src_s;
      dst_r   <= dst_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      error_r <= error_s;
    end
  end

  // Output registers, loaded with the values decoded for the next state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      htrans_r <= HTRANS_IDLE;
      hwrite_r <= 1'b0;
      haddr_r  <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      htrans_r <= htrans_s;
      hwrite_r <= hwrite_s;
      haddr_r  <= haddr_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign HTRANS    = htrans_r;
  assign HWRITE    = hwrite_r;
  assign HADDR     = haddr_r;
  assign HWDATA    = data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_mfp_ahb_dma_master.sv
// tb_mfp_ahb_dma_master: acts as the AHB slave and checks every cycle against
// a phase-list model: a copy is a list of (phase, word, wait-count) entries and
// the expected outputs of each cycle follow from which entry it falls into.
`timescale 1ns/1ps
module tb_mfp_ahb_dma_master;
  localparam int CNT_W = 16;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [CNT_W-1:0] word_cnt;
  logic             busy, done, error;
  logic [31:0]      HADDR, HWDATA, HRDATA;
  logic [1:0]       HTRANS;
  logic             HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;

  always #5 HCLK = ~HCLK;

  mfp_ahb_dma_master #(.CNT_W(CNT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .word_cnt(word_cnt), .busy(busy), .done(done),
    .error(error), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef enum logic [1:0] {PH_RDA = 2'd0, PH_RDD = 2'd1, PH_WRA = 2'd2, PH_WRD = 2'd3} ph_kind_t;
  typedef struct {
    ph_kind_t kind;
    int       idx;
    int       waits;
    bit       err;
  } phase_t;

  phase_t      ph_q[$];
  int          wait_tab [0:63];
  logic [31:0] word_tab [0:15];

  int n_checks = 0;
  int n_pass   = 0;

  // expectation for the current cycle
  bit          exp_valid;
  logic [1:0]  exp_htrans;
  bit          exp_busy, exp_done, exp_err, chk_addr, chk_wdata, exp_hwrite;
  logic [31:0] exp_haddr, exp_hwdata;
  bit          model_err;
  int          cur_cycle;

  // observations of the bus, used for the literal checks
  logic [31:0] obs_rd[$], obs_wr[$], obs_wd[$];
  int          obs_done_cycle;
  bit          pend_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_idle_exp();
    exp_htrans = 2'b00; exp_busy = 1'b0; exp_done = 1'b0; exp_err = model_err;
    chk_addr = 1'b0; chk_wdata = 1'b0; exp_hwrite = 1'b0;
  endtask

  // Per-cycle comparison of the DUT against the model, plus bus observation.
  always @(negedge HCLK) begin
    if (exp_valid && !HRESET) begin
      check("htrans", {30'd0, HTRANS}, {30'd0, exp_htrans});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("error", {31'd0, error}, {31'd0, exp_err});
      check("const_ctl", {21'd0, HBURST, HSIZE, HPROT, HMASTLOCK},
            {21'd0, 3'b000, 3'b010, 4'b0011, 1'b0});
      if (chk_addr) begin
        check("haddr", HADDR, exp_haddr);
        check("hwrite", {31'd0, HWRITE}, {31'd0, exp_hwrite});
      end
      if (chk_wdata) check("hwdata", HWDATA, exp_hwdata);
      if (pend_wr && HREADY) begin
        obs_wd.push_back(HWDATA);
        pend_wr = 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        if (HWRITE) begin
          obs_wr.push_back(HADDR);
          pend_wr = 1'b1;
        end else begin
          obs_rd.push_back(HADDR);
        end
      end
      if (done) obs_done_cycle = cur_cycle;
    end
  end

  task automatic clear_tabs();
    for (int i = 0; i < 64; i++) wait_tab[i] = 0;
    for (int i = 0; i < 16; i++) word_tab[i] = $urandom;
  endtask

  // One copy: build the phase list, then play it cycle by cycle as the slave.
  // ign_mode: 0 none, 1 start pulse on a random busy cycle, 2 start pulse in FIN.
  // rst_phase: phase index at which HRESET is asserted (-1 for none).
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                          input int err_word, input bit err_wr, input int ign_mode,
                          input int rst_phase);
    logic [31:0] sa, da;
    int          t, ign_t, total;
    bit          stop;
    phase_t      p;
    sa = {src[31:2], 2'b00};
    da = {dst[31:2], 2'b00};
    ph_q.delete();
    stop = 1'b0;
    for (int i = 0; i < cnt && !stop; i++) begin
      for (int k = 0; k < 4 && !stop; k++) begin
        p.kind  = ph_kind_t'(k);
        p.idx   = i;
        p.waits = wait_tab[4*i+k];
        p.err   = (i == err_word) && ((k == 1 && !err_wr) || (k == 3 && err_wr));
        ph_q.push_back(p);
        if (p.err) stop = 1'b1;
      end
    end
    total = 0;
    for (int pi = 0; pi < ph_q.size(); pi++) total += 1 + ph_q[pi].waits;
    if (ign_mode == 1 && total > 0) ign_t = 1 + $urandom_range(0, total - 1);
    else if (ign_mode == 2) ign_t = total + 1;
    else ign_t = -1;
    obs_rd.delete(); obs_wr.delete(); obs_wd.delete();
    obs_done_cycle = -1;
    pend_wr = 1'b0;
    // cycle 0: start request in IDLE
    @(posedge HCLK); #1;
    cur_cycle = 0;
    start = 1'b1; src_addr = src; dst_addr = dst; word_cnt = cnt[CNT_W-1:0];
    HREADY = $urandom_range(0, 1); HRESP = 1'b0; HRDATA = $urandom;
    set_idle_exp();
    model_err = 1'b0;
    t = 1;
    for (int pi = 0; pi < ph_q.size(); pi++) begin
      p = ph_q[pi];
      for (int w = 0; w <= p.waits; w++) begin
        @(posedge HCLK); #1;
        if (pi == rst_phase) begin
          exp_valid = 1'b0;
          #2 HRESET = 1'b1;
          #1;
          check("rst_htrans", {30'd0, HTRANS}, 32'd0);
          check("rst_busy", {31'd0, busy}, 32'd0);
          check("rst_haddr", HADDR, 32'd0);
          check("rst_hwdata", HWDATA, 32'd0);
          check("rst_error", {31'd0, error}, 32'd0);
          @(posedge HCLK); #1;
          HRESET = 1'b0; start = 1'b0; HRESP = 1'b0;
          model_err = 1'b0;
          set_idle_exp();
          exp_valid = 1'b1;
          repeat (3) begin
            @(posedge HCLK); #1;
            HREADY = $urandom_range(0, 1);
          end
          return;
        end
        cur_cycle = t;
        start = (t == ign_t);
        src_addr = $urandom; dst_addr = $urandom; word_cnt = $urandom;
        HREADY = (w == p.waits);
        HRESP  = p.err || ((p.kind == PH_RDA || p.kind == PH_WRA) && ($urandom % 4 == 0));
        HRDATA = (p.kind == PH_RDD && HREADY) ? word_tab[p.idx] : $urandom;
        exp_htrans = (p.kind == PH_RDA || p.kind == PH_WRA) ? 2'b10 : 2'b00;
        exp_busy = 1'b1; exp_done = 1'b0; exp_err = model_err;
        chk_addr = (p.kind == PH_RDA || p.kind == PH_WRA);
        exp_haddr = (p.kind == PH_RDA) ? sa + 32'(4 * p.idx) : da + 32'(4 * p.idx);
        exp_hwrite = (p.kind == PH_WRA);
        chk_wdata = (p.kind == PH_WRA || p.kind == PH_WRD);
        exp_hwdata = word_tab[p.idx];
        t++;
      end
      if (p.err) model_err = 1'b1;
    end
    // FIN cycle
    @(posedge HCLK); #1;
    cur_cycle = t;
    start = (t == ign_t); word_cnt = $urandom;
    HREADY = $urandom_range(0, 1); HRESP = $urandom_range(0, 1); HRDATA = $urandom;
    set_idle_exp();
    exp_busy = 1'b1; exp_done = 1'b1;
    // back in IDLE
    repeat (2) begin
      @(posedge HCLK); #1;
      cur_cycle++;
      start = 1'b0;
      HREADY = $urandom_range(0, 1); HRESP = $urandom_range(0, 1);
      set_idle_exp();
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int cnt, ew, rp;
    logic [31:0] src;
    HRESET = 1'b1; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0;
    word_cnt = '0; HRDATA = 32'd0; HREADY = 1'b1; HRESP = 1'b0;
    exp_valid = 1'b0; model_err = 1'b0; cur_cycle = 0; pend_wr = 1'b0;
    obs_done_cycle = -1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("reset_htrans", {30'd0, HTRANS}, 32'd0);
    check("reset_hwrite", {31'd0, HWRITE}, 32'd0);
    check("reset_haddr", HADDR, 32'd0);
    check("reset_hwdata", HWDATA, 32'd0);
    check("reset_flags", {29'd0, busy, done, error}, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    set_idle_exp();
    exp_valid = 1'b1;

    // zero-wait three-word copy
    clear_tabs();
    run_copy(32'h8000_0100, 32'h8000_0200, 3, -1, 1'b0, 1, -1);
    check("zw_done_cycle", 32'(obs_done_cycle), 32'd13);
    check("zw_rd0", q_at(obs_rd, 0), 32'h8000_0100);
    check("zw_rd1", q_at(obs_rd, 1), 32'h8000_0104);
    check("zw_rd2", q_at(obs_rd, 2), 32'h8000_0108);
    check("zw_wr2", q_at(obs_wr, 2), 32'h8000_0208);
    check("zw_wd1", q_at(obs_wd, 1), word_tab[1]);
    check("zw_error", {31'd0, error}, 32'd0);

    // wait states in RD_A and WR_D on one word
    clear_tabs();
    wait_tab[0] = 2; wait_tab[3] = 2;
    run_copy(32'h1000_0040, 32'h2000_0080, 1, -1, 1'b0, 0, -1);
    check("ws_done_cycle", 32'(obs_done_cycle), 32'd9);
    check("ws_wd0", q_at(obs_wd, 0), word_tab[0]);

    // zero count, then misaligned source
    clear_tabs();
    run_copy(32'h8000_0000, 32'h9000_0000, 0, -1, 1'b0, 2, -1);
    check("zc_done_cycle", 32'(obs_done_cycle), 32'd1);
    check("zc_no_xfer", 32'(obs_rd.size() + obs_wr.size()), 32'd0);
    run_copy(32'h8000_0003, 32'h9000_0002, 1, -1, 1'b0, 0, -1);
    check("mis_rd0", q_at(obs_rd, 0), 32'h8000_0000);
    check("mis_wr0", q_at(obs_wr, 0), 32'h9000_0000);

    // read error on the second word of four
    clear_tabs();
    run_copy(32'h0000_1000, 32'h0000_2000, 4, 1, 1'b0, 1, -1);
    check("err_writes", 32'(obs_wr.size()), 32'd1);
    check("err_done_cycle", 32'(obs_done_cycle), 32'd7);
    check("err_sticky", {31'd0, error}, 32'd1);
    run_copy(32'h0000_3000, 32'h0000_4000, 1, -1, 1'b0, 0, -1);
    check("err_cleared", {31'd0, error}, 32'd0);

    // address wrap, start in FIN, then reset in WR_A
    clear_tabs();
    run_copy(32'hFFFF_FFFC, 32'h0000_5000, 2, -1, 1'b0, 2, -1);
    check("wrap_rd1", q_at(obs_rd, 1), 32'h0000_0000);
    check("wrap_reads", 32'(obs_rd.size()), 32'd2);
    run_copy(32'h0000_6000, 32'h0000_7000, 2, -1, 1'b0, 0, 2);
    check("post_rst_no_write", 32'(obs_wr.size()), 32'd0);

    // randomized copies
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 16; i++) word_tab[i] = $urandom;
      for (int i = 0; i < 64; i++) wait_tab[i] = ($urandom % 2 == 0) ? $urandom_range(0, 3) : 0;
      cnt = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 6);
      ew  = (cnt > 0 && $urandom % 4 == 0) ? $urandom_range(0, cnt - 1) : -1;
      rp  = (cnt > 0 && $urandom % 8 == 0) ? $urandom_range(0, 4 * cnt - 1) : -1;
      src = ($urandom % 3 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      run_copy(src, $urandom, cnt, ew, 1'($urandom_range(0, 1)), $urandom_range(0, 2), rp);
    end

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
